// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: instruction memory port, redirect input and decode handshake.
// The fetch queue drives the master modport; its environment uses the slave modport.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4
) ();
    logic                     imem_req;
    logic [31:0]              imem_addr;
    logic [31:0]              imem_insn;
    logic                     redirect_valid;
    logic [31:0]              redirect_pc;
    logic                     id_ready;
    logic                     if_valid;
    logic [31:0]              if_insn;
    logic [31:0]              if_pc;
    logic [$clog2(DEPTH):0]   if_count;

    modport master (
        output imem_req, imem_addr, if_valid, if_insn, if_pc, if_count,
        input  imem_insn, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_insn, if_pc, if_count,
        output imem_insn, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: sequential word fetch, one-cycle memory latency, prefetch FIFO.
// Define FETCH_QUEUE_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clk,
    input logic           rst_n,
    fetch_queue_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    logic [31:0]   r_fetch_pc;
    logic          r_inflight;
    logic [31:0]   r_inflight_pc;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_mem_insn [DEPTH];
    logic [31:0]   r_mem_pc   [DEPTH];

    logic [CW:0]   w_occ;
    logic          w_req;
    logic          w_fifo_valid;
    logic          w_bypass;
    logic          w_valid;
    logic          w_push;
    logic          w_pop;
    logic          w_unused;

    assign w_unused = ^bus.redirect_pc[1:0];

    // An in-flight request already owns a slot, so it counts toward occupancy.
    assign w_occ        = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_req        = rst_n && !bus.redirect_valid && (w_occ < DEPTH_W);
    assign w_fifo_valid = (r_count != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = !w_fifo_valid && r_inflight && !bus.redirect_valid;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_valid = w_fifo_valid || w_bypass;
    assign w_pop   = w_fifo_valid && bus.id_ready && !bus.redirect_valid;
    assign w_push  = r_inflight && !bus.redirect_valid && !(w_bypass && bus.id_ready);

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_fetch_pc;
    assign bus.if_valid  = w_valid;
    assign bus.if_count  = r_count;

    always_comb begin
        bus.if_insn = 32'h0;
        bus.if_pc   = 32'h0;
        if (w_fifo_valid) begin
            bus.if_insn = r_mem_insn[r_rd_ptr];
            bus.if_pc   = r_mem_pc[r_rd_ptr];
        end else if (w_bypass) begin
            bus.if_insn = bus.imem_insn;
            bus.if_pc   = r_inflight_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'h0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
        end else if (bus.redirect_valid) begin
            r_fetch_pc    <= {bus.redirect_pc[31:2], 2'b00};
            r_inflight    <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_fetch_pc    <= r_fetch_pc + 32'd4;
                r_inflight_pc <= r_fetch_pc;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_insn[r_wr_ptr] <= bus.imem_insn;
            r_mem_pc[r_wr_ptr]   <= r_inflight_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed phases plus random ready/redirect traffic,
// compared each cycle against a queue-based reference model of the fetch front end.
`timescale 1ns/1ps
module tb_fetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: queued PCs, the in-flight fetch and the next fetch address.
    logic [31:0] q[$];
    bit          m_infl;
    logic [31:0] m_infl_pc;
    logic [31:0] m_fpc;
    bit          resp_pend;
    logic [31:0] resp_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_infl    = 1'b0;
        m_infl_pc = 32'h0;
        m_fpc     = RESET_PC;
        resp_pend = 1'b0;
        resp_addr = 32'h0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_imem_req"},  32'(bus.imem_req), 32'h0);
        chk({tag, "_imem_addr"}, bus.imem_addr, RESET_PC);
        chk({tag, "_if_valid"},  32'(bus.if_valid), 32'h0);
        chk({tag, "_if_insn"},   bus.if_insn, 32'h0);
        chk({tag, "_if_pc"},     bus.if_pc, 32'h0);
        chk({tag, "_if_count"},  32'(bus.if_count), 32'h0);
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic cycle(input bit rdy, input bit rv, input logic [31:0] rpc);
        bit          req;
        bit          byp;
        bit          exp_valid;
        bit          popq;
        logic [31:0] hpc;
        bus.id_ready       = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.imem_insn      = resp_pend ? mem_word(resp_addr) : $urandom;
        #1;
        req       = !rv && (q.size() + int'(m_infl) < DEPTH);
        byp       = BYP && (q.size() == 0) && m_infl && !rv;
        exp_valid = (q.size() != 0) || byp;
        hpc       = (q.size() != 0) ? q[0] : m_infl_pc;
        chk("imem_req",  32'(bus.imem_req), 32'(req));
        chk("imem_addr", bus.imem_addr, m_fpc);
        chk("if_valid",  32'(bus.if_valid), 32'(exp_valid));
        chk("if_count",  32'(bus.if_count), 32'(q.size()));
        if (exp_valid) begin
            chk("if_pc",   bus.if_pc, hpc);
            chk("if_insn", bus.if_insn, mem_word(hpc));
        end
        resp_pend = bus.imem_req;
        resp_addr = bus.imem_addr;
        if (rv) begin
            q.delete();
            m_infl = 1'b0;
            m_fpc  = {rpc[31:2], 2'b00};
        end else begin
            popq = (q.size() != 0) && rdy;
            if (popq) void'(q.pop_front());
            if (m_infl && !(byp && rdy)) q.push_back(m_infl_pc);
            if (req) begin
                m_infl    = 1'b1;
                m_infl_pc = m_fpc;
                m_fpc     = m_fpc + 32'd4;
            end else begin
                m_infl = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_insn      = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");
        rst_n = 1'b1;

        // Streaming from RESET_PC with decode always ready.
        repeat (12) cycle(1'b1, 1'b0, 32'h0);

        // Decode stalled: queue fills and fetching stops.
        repeat (10) cycle(1'b0, 1'b0, 32'h0);
        chk("stall_count", 32'(bus.if_count), DEPTH);
        chk("stall_req", 32'(bus.imem_req), 32'h0);
        repeat (8) cycle(1'b1, 1'b0, 32'h0);

        // Redirect with three queued entries and one fetch in flight.
        for (int i = 0; i < 10 && !(q.size() == 3 && m_infl); i++) cycle(1'b0, 1'b0, 32'h0);
        chk("redir_setup_count", 32'(bus.if_count), 32'd3);
        cycle(1'b1, 1'b1, 32'h0000_0200);
        chk("post_redir_valid", 32'(bus.if_valid), 32'h0);
        repeat (5) cycle(1'b1, 1'b0, 32'h0);

        // Misaligned target, address wrap, and back-to-back redirects.
        cycle(1'b1, 1'b1, 32'h0000_0103);
        repeat (4) cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (6) cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h0000_0040);
        cycle(1'b1, 1'b1, 32'h0000_0080);
        repeat (4) cycle(1'b1, 1'b0, 32'h0);

        // Random decode back-pressure and occasional redirects.
        repeat (300) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom);

        // Asynchronous reset in the middle of a cycle with two entries queued.
        cycle(1'b1, 1'b1, 32'h0000_0300);
        for (int i = 0; i < 10 && q.size() != 2; i++) cycle(1'b0, 1'b0, 32'h0);
        chk("midrst_setup_count", 32'(bus.if_count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        model_reset();
        @(posedge clk);
        #1;
        chk_reset("midrst_hold");
        rst_n = 1'b1;
        repeat (8) cycle(1'b1, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
